// File: rtl/diff_fm_loader_if.sv
// Byte-stream bundle feeding the fm/guard loader: one 8-bit feature-map
// stream and one 6-bit guard stream, each with a valid/ready handshake.
interface diff_fm_loader_if;
  logic       s_fm_valid;
  logic       s_fm_ready;
  logic [7:0] s_fm_data;
  logic       s_gd_valid;
  logic       s_gd_ready;
  logic [5:0] s_gd_data;

  // Source side (DMA / host): drives valid and data, observes ready.
  modport master (
    output s_fm_valid, s_fm_data, s_gd_valid, s_gd_data,
    input  s_fm_ready, s_gd_ready
  );

  // Sink side (loader): observes valid and data, drives ready.
  modport slave (
    input  s_fm_valid, s_fm_data, s_gd_valid, s_gd_data,
    output s_fm_ready, s_gd_ready
  );
endinterface

// File: rtl/diff_fm_loader.sv
// Frame loader for the core's per-column fm and guard buffers.
// A frame first streams fm bytes, then guard words; each stream is spread
// round-robin over PE_COL columns (column first, then address), and every
// accepted beat becomes a registered one-hot write on the next cycle.
module diff_fm_loader #(
  parameter  int PE_COL   = 4,
  parameter  int FM_DEPTH = 1024,
  parameter  int GD_DEPTH = 256,
  localparam int FM_AW    = $clog2(FM_DEPTH),
  localparam int GD_AW    = $clog2(GD_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_start,
  input  logic [FM_AW:0]            cfg_fm_words,
  input  logic [GD_AW:0]            cfg_gd_words,
  input  logic                      cfg_ping_pong,
  output logic                      busy,
  output logic                      done,
  diff_fm_loader_if.slave           strm,
  output logic [PE_COL*FM_AW-1:0]   load_fm_wr_addr,
  output logic [PE_COL*8-1:0]       load_fm_din,
  output logic [PE_COL-1:0]         load_fm_wr_en,
  output logic [PE_COL-1:0]         load_fm_ping_pong,
  output logic [PE_COL*GD_AW-1:0]   load_gd_wr_addr,
  output logic [PE_COL*6-1:0]       load_gd_din,
  output logic [PE_COL-1:0]         load_gd_wr_en,
  output logic [PE_COL-1:0]         load_gd_ping_pong
);

  localparam int COL_W  = (PE_COL > 1) ? $clog2(PE_COL) : 1;
  // One address counter serves both phases, so it is as wide as the larger buffer.
  localparam int CNT_AW = (FM_AW > GD_AW) ? FM_AW : GD_AW;

  localparam logic [FM_AW:0]    FM_DEPTH_W = (FM_AW+1)'(FM_DEPTH);
  localparam logic [GD_AW:0]    GD_DEPTH_W = (GD_AW+1)'(GD_DEPTH);
  localparam logic [CNT_AW:0]   CNT_ONE    = (CNT_AW+1)'(1);
  localparam logic [CNT_AW-1:0] ADDR_ONE   = CNT_AW'(1);
  localparam logic [COL_W-1:0]  COL_ONE    = COL_W'(1);
  localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(PE_COL-1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD_FM = 2'd1,
    S_LOAD_GD = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t              state_reg;
  state_t              state_next;

  logic [FM_AW:0]      fm_words_reg;
  logic [GD_AW:0]      gd_words_reg;
  logic                bank_reg;
  logic [COL_W-1:0]    col_reg;
  logic [CNT_AW-1:0]   addr_reg;

  logic [FM_AW:0]      fm_words_sat;
  logic [GD_AW:0]      gd_words_sat;
  logic                start_ok;
  logic                fm_ready;
  logic                gd_ready;
  logic                fm_fire;
  logic                gd_fire;
  logic                col_last;
  logic [CNT_AW:0]     fm_end_addr;
  logic [CNT_AW:0]     gd_end_addr;
  logic                fm_last;
  logic                gd_last;

  // Oversized word counts clamp to the buffer depth so addresses never wrap.
  assign fm_words_sat = (cfg_fm_words > FM_DEPTH_W) ? FM_DEPTH_W : cfg_fm_words;
  assign gd_words_sat = (cfg_gd_words > GD_DEPTH_W) ? GD_DEPTH_W : cfg_gd_words;

  // A start is only honoured while idle; pulses during a frame are dropped.
  assign start_ok = cfg_start && (state_reg == S_IDLE);

  assign fm_fire  = strm.s_fm_valid && fm_ready;
  assign gd_fire  = strm.s_gd_valid && gd_ready;
  assign col_last = (col_reg == COL_LAST);

  // Last address of each phase; only meaningful while that phase's count is non-zero.
  assign fm_end_addr = (CNT_AW+1)'(fm_words_reg) - CNT_ONE;
  assign gd_end_addr = (CNT_AW+1)'(gd_words_reg) - CNT_ONE;
  assign fm_last     = fm_fire && col_last && ({1'b0, addr_reg} == fm_end_addr);
  assign gd_last     = gd_fire && col_last && ({1'b0, addr_reg} == gd_end_addr);

  assign strm.s_fm_ready = fm_ready;
  assign strm.s_gd_ready = gd_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decision: skip empty phases straight through to DONE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start_ok) begin
          if (fm_words_sat != '0) begin
            state_next = S_LOAD_FM;
          end else if (gd_words_sat != '0) begin
            state_next = S_LOAD_GD;
          end else begin
            state_next = S_DONE;
          end
        end
      end
      S_LOAD_FM: begin
        if (fm_last) begin
          state_next = (gd_words_reg != '0) ? S_LOAD_GD : S_DONE;
        end
      end
      S_LOAD_GD: begin
        if (gd_last) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Status and ready are pure decodes of the state register, independent of valid.
  always_comb begin
    fm_ready = 1'b0;
    gd_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_reg)
      S_LOAD_FM: begin
        fm_ready = 1'b1;
        busy     = 1'b1;
      end
      S_LOAD_GD: begin
        gd_ready = 1'b1;
        busy     = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        fm_ready = 1'b0;
      end
    endcase
  end

  // Frame configuration, captured only on an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fm_words_reg <= '0;
      gd_words_reg <= '0;
      bank_reg     <= 1'b0;
    end else if (start_ok) begin
      fm_words_reg <= fm_words_sat;
      gd_words_reg <= gd_words_sat;
      bank_reg     <= cfg_ping_pong;
    end
  end

  // Column/address walk: column advances every beat, address on column wrap;
  // both restart at zero between phases and while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_reg  <= '0;
      addr_reg <= '0;
    end else if (state_reg == S_IDLE) begin
      col_reg  <= '0;
      addr_reg <= '0;
    end else if (fm_fire || gd_fire) begin
      if (fm_last || gd_last) begin
        col_reg  <= '0;
        addr_reg <= '0;
      end else if (col_last) begin
        col_reg  <= '0;
        addr_reg <= addr_reg + ADDR_ONE;
      end else begin
        col_reg  <= col_reg + COL_ONE;
      end
    end
  end

  assign load_fm_ping_pong = {PE_COL{bank_reg}};
  assign load_gd_ping_pong = {PE_COL{bank_reg}};

  genvar gi;
  generate
    for (gi = 0; gi < PE_COL; gi++) begin : g_col
      logic             sel;
      logic             fm_wr_en_reg;
      logic [FM_AW-1:0] fm_addr_reg;
      logic [7:0]       fm_din_reg;
      logic             gd_wr_en_reg;
      logic [GD_AW-1:0] gd_addr_reg;
      logic [5:0]       gd_din_reg;

      assign sel = (col_reg == COL_W'(gi));

      // Per-column write port: strobe for one cycle, address/data hold when idle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          fm_wr_en_reg <= 1'b0;
          fm_addr_reg  <= '0;
          fm_din_reg   <= '0;
          gd_wr_en_reg <= 1'b0;
          gd_addr_reg  <= '0;
          gd_din_reg   <= '0;
        end else begin
          fm_wr_en_reg <= fm_fire && sel;
          gd_wr_en_reg <= gd_fire && sel;
          if (fm_fire && sel) begin
            fm_addr_reg <= addr_reg[FM_AW-1:0];
            fm_din_reg  <= strm.s_fm_data;
          end
          if (gd_fire && sel) begin
            gd_addr_reg <= addr_reg[GD_AW-1:0];
            gd_din_reg  <= strm.s_gd_data;
          end
        end
      end

      assign load_fm_wr_en[gi]                  = fm_wr_en_reg;
      assign load_fm_wr_addr[gi*FM_AW +: FM_AW] = fm_addr_reg;
      assign load_fm_din[gi*8 +: 8]             = fm_din_reg;
      assign load_gd_wr_en[gi]                  = gd_wr_en_reg;
      assign load_gd_wr_addr[gi*GD_AW +: GD_AW] = gd_addr_reg;
      assign load_gd_din[gi*6 +: 6]             = gd_din_reg;
    end
  endgenerate

endmodule

// File: tb/tb_diff_fm_loader.sv
// Scoreboard bench for diff_fm_loader: frames are described as byte lists,
// the expected column/address of every write is derived arithmetically
// (beat k -> column k mod PE_COL, address k div PE_COL) and a negedge
// monitor pops and compares each write the DUT produces.
module tb_diff_fm_loader;
  localparam int PE_COL   = 4;
  localparam int FM_DEPTH = 1024;
  localparam int GD_DEPTH = 256;
  localparam int FM_AW    = $clog2(FM_DEPTH);
  localparam int GD_AW    = $clog2(GD_DEPTH);

  typedef struct {
    bit gd;
    int col;
    int addr;
    int data;
    bit bank;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_start = 1'b0;
  logic [FM_AW:0] cfg_fm_words = '0;
  logic [GD_AW:0] cfg_gd_words = '0;
  logic cfg_ping_pong = 1'b0;
  logic busy, done;
  logic [PE_COL*FM_AW-1:0] fm_addr;
  logic [PE_COL*8-1:0]     fm_din;
  logic [PE_COL-1:0]       fm_wr_en, fm_pp;
  logic [PE_COL*GD_AW-1:0] gd_addr;
  logic [PE_COL*6-1:0]     gd_din;
  logic [PE_COL-1:0]       gd_wr_en, gd_pp;

  diff_fm_loader_if sif ();

  diff_fm_loader #(.PE_COL(PE_COL), .FM_DEPTH(FM_DEPTH), .GD_DEPTH(GD_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start),
    .cfg_fm_words(cfg_fm_words), .cfg_gd_words(cfg_gd_words), .cfg_ping_pong(cfg_ping_pong),
    .busy(busy), .done(done), .strm(sif.slave),
    .load_fm_wr_addr(fm_addr), .load_fm_din(fm_din), .load_fm_wr_en(fm_wr_en),
    .load_fm_ping_pong(fm_pp),
    .load_gd_wr_addr(gd_addr), .load_gd_din(gd_din), .load_gd_wr_en(gd_wr_en),
    .load_gd_ping_pong(gd_pp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  wr_t exp_q[$];
  int fm_src_q[$];
  int gd_src_q[$];
  int valid_pct = 100;
  bit mon_en = 1'b0;
  bit fm_acc_seen = 1'b0;
  bit gd_acc_seen = 1'b0;
  int done_cnt = 0;
  int last_fm_addr = -1;
  int last_gd_addr = -1;
  int frame_no = 0;

  function automatic void chk(bit ok, string name, int act, int exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  // Compare one DUT write against the head of the expected queue.
  function automatic void check_write(bit is_gd);
    logic [PE_COL-1:0] en;
    wr_t e;
    int c, a, d, pp;
    en = is_gd ? gd_wr_en : fm_wr_en;
    chk($countones(en) == 1, is_gd ? "gd_wr_en_onehot" : "fm_wr_en_onehot", int'(en), 1);
    c = 0;
    for (int i = 0; i < PE_COL; i++) begin
      if (en[i]) begin
        c = i;
        break;
      end
    end
    if (is_gd) begin
      a  = int'(gd_addr[c*GD_AW +: GD_AW]);
      d  = int'(gd_din[c*6 +: 6]);
      pp = int'(gd_pp);
      last_gd_addr = a;
    end else begin
      a  = int'(fm_addr[c*FM_AW +: FM_AW]);
      d  = int'(fm_din[c*8 +: 8]);
      pp = int'(fm_pp);
      last_fm_addr = a;
    end
    if (exp_q.size() == 0) begin
      chk(1'b0, "unexpected_write", c, -1);
    end else begin
      e = exp_q.pop_front();
      chk(e.gd == is_gd, "write_stream", int'(is_gd), int'(e.gd));
      chk(c == e.col, "write_col", c, e.col);
      chk(a == e.addr, "write_addr", a, e.addr);
      chk(d == e.data, "write_data", d, e.data);
      chk(pp == (e.bank ? (1 << PE_COL) - 1 : 0), "ping_pong", pp, e.bank ? (1 << PE_COL) - 1 : 0);
    end
  endfunction

  // Stream driver: decides acceptance at the negedge, consumes after the posedge.
  initial begin
    bit acc_fm, acc_gd;
    sif.s_fm_valid = 1'b0;
    sif.s_fm_data  = '0;
    sif.s_gd_valid = 1'b0;
    sif.s_gd_data  = '0;
    forever begin
      @(negedge clk);
      acc_fm = sif.s_fm_valid && sif.s_fm_ready;
      acc_gd = sif.s_gd_valid && sif.s_gd_ready;
      @(posedge clk);
      #1;
      fm_acc_seen = acc_fm;
      gd_acc_seen = acc_gd;
      if (acc_fm && fm_src_q.size() > 0) void'(fm_src_q.pop_front());
      if (acc_gd && gd_src_q.size() > 0) void'(gd_src_q.pop_front());
      if (fm_src_q.size() > 0 && $urandom_range(99, 0) < valid_pct) begin
        sif.s_fm_valid = 1'b1;
        sif.s_fm_data  = 8'(fm_src_q[0]);
      end else begin
        sif.s_fm_valid = 1'b0;
        sif.s_fm_data  = 8'($urandom);
      end
      if (gd_src_q.size() > 0 && $urandom_range(99, 0) < valid_pct) begin
        sif.s_gd_valid = 1'b1;
        sif.s_gd_data  = 6'(gd_src_q[0]);
      end else begin
        sif.s_gd_valid = 1'b0;
        sif.s_gd_data  = 6'($urandom);
      end
    end
  end

  // Monitor: every write must follow an accepted beat and match the scoreboard.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (mon_en) begin
      chk((|fm_wr_en) == fm_acc_seen, "fm_wr_en_vs_accept", int'(|fm_wr_en), int'(fm_acc_seen));
      chk((|gd_wr_en) == gd_acc_seen, "gd_wr_en_vs_accept", int'(|gd_wr_en), int'(gd_acc_seen));
      if (|fm_wr_en) check_write(1'b0);
      if (|gd_wr_en) check_write(1'b1);
    end
  end

  // Queue the frame's source bytes and expected writes, then pulse cfg_start.
  task automatic start_frame(input int fm, input int gd, input bit bank);
    int fme, gde, b;
    fme = (fm > FM_DEPTH) ? FM_DEPTH : fm;
    gde = (gd > GD_DEPTH) ? GD_DEPTH : gd;
    @(posedge clk);
    for (int k = 0; k < PE_COL * fme; k++) begin
      b = int'($urandom_range(255, 0));
      fm_src_q.push_back(b);
      exp_q.push_back('{gd: 1'b0, col: k % PE_COL, addr: k / PE_COL, data: b, bank: bank});
    end
    for (int k = 0; k < PE_COL * gde; k++) begin
      b = int'($urandom_range(63, 0));
      gd_src_q.push_back(b);
      exp_q.push_back('{gd: 1'b1, col: k % PE_COL, addr: k / PE_COL, data: b, bank: bank});
    end
    #2;
    cfg_fm_words  = (FM_AW+1)'(fm);
    cfg_gd_words  = (GD_AW+1)'(gd);
    cfg_ping_pong = bank;
    cfg_start     = 1'b1;
    @(posedge clk);
    #2;
    cfg_start = 1'b0;
    frame_no++;
    $display("frame %0d start fm=%0d gd=%0d bank=%0d", frame_no, fm, gd, bank);
  endtask

  // Wait (bounded) for done; report latency, busy cycles and ready cycles.
  task automatic wait_done(input int budget, output int cyc, output int busy_n, output int rdy_n);
    bit seen;
    cyc = 0; busy_n = 0; rdy_n = 0; seen = 1'b0;
    while (!seen && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_n++;
      if (sif.s_fm_ready || sif.s_gd_ready) rdy_n++;
      if (done) seen = 1'b1;
    end
    chk(seen, "done_timeout", cyc, budget);
    @(negedge clk);
    chk(done == 1'b0, "done_one_cycle", int'(done), 0);
    chk(busy == 1'b0, "busy_after_done", int'(busy), 0);
    chk(exp_q.size() == 0, "all_writes_seen", exp_q.size(), 0);
    $display("frame %0d done cycles=%0d busy=%0d ready=%0d", frame_no, cyc, busy_n, rdy_n);
  endtask

  task automatic check_cleared(input string tag);
    chk(fm_wr_en == '0 && gd_wr_en == '0, {tag, "_wr_en"}, int'({fm_wr_en, gd_wr_en}), 0);
    chk(busy == 1'b0 && done == 1'b0, {tag, "_busy_done"}, int'({busy, done}), 0);
    chk(sif.s_fm_ready == 1'b0 && sif.s_gd_ready == 1'b0, {tag, "_ready"},
        int'({sif.s_fm_ready, sif.s_gd_ready}), 0);
    chk(fm_pp == '0 && gd_pp == '0, {tag, "_ping_pong"}, int'({fm_pp, gd_pp}), 0);
    chk(fm_addr == '0 && gd_addr == '0, {tag, "_addr"}, int'(fm_addr != '0) + int'(gd_addr != '0), 0);
    chk(fm_din == '0 && gd_din == '0, {tag, "_din"}, int'(fm_din != '0) + int'(gd_din != '0), 0);
  endtask

  initial begin
    int cyc, bn, rn, dbefore, fm, gd;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #2 mon_en = 1'b1;

    // Directed frame, streams always valid: exact latency and busy span.
    valid_pct = 100;
    start_frame(2, 1, 1'b1);
    wait_done(200, cyc, bn, rn);
    chk(cyc == 13, "t1_done_latency", cyc, 13);
    chk(bn == 13, "t1_busy_cycles", bn, 13);
    chk(int'(fm_pp) == 15 && int'(gd_pp) == 15, "t1_ping_pong_hold", int'(fm_pp), 15);

    // Empty frame: straight to done, no writes, readys never rise.
    start_frame(0, 0, 1'b0);
    wait_done(20, cyc, bn, rn);
    chk(cyc == 1, "t3_done_latency", cyc, 1);
    chk(bn == 1, "t3_busy_cycles", bn, 1);
    chk(rn == 0, "t3_ready_cycles", rn, 0);
    chk(fm_pp == '0, "t3_ping_pong", int'(fm_pp), 0);

    // Random frames with random valid gaps on both streams.
    for (int f = 0; f < 8; f++) begin
      valid_pct = int'($urandom_range(90, 30));
      fm = int'($urandom_range(6, 0));
      gd = int'($urandom_range(4, 0));
      start_frame(fm, gd, 1'($urandom_range(1, 0)));
      wait_done(2000, cyc, bn, rn);
    end

    // Start re-pulsed mid-frame with different cfg: must be ignored.
    valid_pct = 70;
    start_frame(3, 2, 1'b1);
    repeat (4) @(posedge clk);
    #2;
    cfg_fm_words = (FM_AW+1)'(7);
    cfg_gd_words = (GD_AW+1)'(5);
    cfg_ping_pong = 1'b0;
    cfg_start = 1'b1;
    @(posedge clk);
    #2 cfg_start = 1'b0;
    wait_done(2000, cyc, bn, rn);
    chk(int'(fm_pp) == 15, "t4_bank_kept", int'(fm_pp), 15);

    // Oversized counts saturate to the buffer depth without wrapping.
    valid_pct = 100;
    start_frame(FM_DEPTH + 5, GD_DEPTH + 3, 1'b0);
    wait_done(20000, cyc, bn, rn);
    chk(last_fm_addr == FM_DEPTH - 1, "t5_last_fm_addr", last_fm_addr, FM_DEPTH - 1);
    chk(last_gd_addr == GD_DEPTH - 1, "t5_last_gd_addr", last_gd_addr, GD_DEPTH - 1);
    chk(cyc == PE_COL * (FM_DEPTH + GD_DEPTH) + 1, "t5_done_latency", cyc, PE_COL * (FM_DEPTH + GD_DEPTH) + 1);

    // Reset in the middle of LOAD_FM: immediate clear, no done, clean restart.
    start_frame(3, 2, 1'b1);
    repeat (5) @(posedge clk);
    #3;
    dbefore = done_cnt;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check_cleared("t6_async");
    exp_q.delete();
    fm_src_q.delete();
    gd_src_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2 mon_en = 1'b1;
    chk(done_cnt == dbefore, "t6_no_done", done_cnt, dbefore);
    start_frame(2, 1, 1'b0);
    wait_done(200, cyc, bn, rn);
    chk(cyc == 13, "t6_restart_latency", cyc, 13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
